// File: rtl/pl_hazard_ctrl_pkg.sv
//==============================================================================
// Module : pl_hazard_ctrl_pkg
// Brief  : Shared FSM state encodings, forward-select codes and forward helper.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package pl_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FAULT    = 2'd2
    } state_t;

    localparam logic [1:0] c_FWD_RF = 2'b00;
    localparam logic [1:0] c_FWD_W  = 2'b01;
    localparam logic [1:0] c_FWD_M  = 2'b10;

    // M has priority over W because it holds the younger result; x0 is hardwired zero.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic [4:0] rd_w,
        input logic       we_m,
        input logic       we_w
    );
        if (we_m && (rs == rd_m) && (rs != 5'd0))
            return c_FWD_M;
        else if (we_w && (rs == rd_w) && (rs != 5'd0))
            return c_FWD_W;
        else
            return c_FWD_RF;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pl_mem_wait_fsm.sv
//==============================================================================
// Module : pl_mem_wait_fsm
// Brief  : Memory-wait sequencer: freezes the pipeline while data memory stalls,
//          declares a sticky timeout fault after TIMEOUT_CYC wait cycles.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module pl_mem_wait_fsm
    import pl_hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic i_mem_req,
    input  logic i_mem_ready,
    output logic o_freeze,
    output logic o_timeout
);

    localparam int c_WCNT_W = (TIMEOUT_CYC <= 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [c_WCNT_W-1:0] c_WCNT_LAST = c_WCNT_W'(TIMEOUT_CYC - 1);

    state_t              r_state;
    logic [c_WCNT_W-1:0] r_wait_cnt;
    logic                r_timeout;
    logic                w_mem_wait;

    assign w_mem_wait = i_mem_req && !i_mem_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_mem_wait) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                ST_MEM_WAIT: begin
                    if (i_mem_ready) begin
                        r_state <= ST_RUN;
                    end else if (w_mem_wait) begin
                        if (r_wait_cnt == c_WCNT_LAST) begin
                            r_state   <= ST_FAULT;
                            r_timeout <= 1'b1;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 1'b1;
                        end
                    end
                end
                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    // Freeze reacts to memWait in the same cycle; FAULT keeps it asserted until reset.
    assign o_freeze  = w_mem_wait || (r_state == ST_FAULT);
    assign o_timeout = r_timeout;

endmodule

`default_nettype wire

// File: rtl/pl_hazard_ctrl.sv
//==============================================================================
// Module : pl_hazard_ctrl
// Brief  : 5-stage pipeline hazard controller: forwarding, load-use stall, branch
//          flush, memory-wait freeze and saturating stall/flush counters.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module pl_hazard_ctrl
    import pl_hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             ResultSrcE0,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    logic             w_freeze;
    logic             w_lw_stall;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    pl_mem_wait_fsm #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_mem_wait_fsm (
        .clk         (clk),
        .reset       (reset),
        .i_mem_req   (MemReqM),
        .i_mem_ready (MemReadyM),
        .o_freeze    (w_freeze),
        .o_timeout   (MemTimeout)
    );

    assign w_lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((Rs1D == RdE) || (Rs2D == RdE));

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        ForwardAE = c_FWD_RF;
        ForwardBE = c_FWD_RF;
        if (reset) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else begin
            ForwardAE = fwd_sel(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
            ForwardBE = fwd_sel(Rs2E, RdM, RdW, RegWriteM, RegWriteW);
            // E is held during a freeze, so a pending PCSrcE is simply re-seen afterwards.
            if (w_freeze) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else begin
                StallF = w_lw_stall;
                StallD = w_lw_stall;
                FlushD = PCSrcE;
                FlushE = w_lw_stall || PCSrcE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (StallF && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (!w_freeze && PCSrcE && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign StallCount = r_stall_cnt;
    assign FlushCount = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pl_hazard_ctrl.sv
//==============================================================================
// Module : tb_pl_hazard_ctrl
// Brief  : Directed self-checking bench; a default instance and a small
//          instance (TIMEOUT_CYC=4, CNT_W=2) share one set of inputs.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_pl_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;

    logic        m_StallF, m_StallD, m_StallE, m_StallM, m_FlushD, m_FlushE, m_FlushW;
    logic [1:0]  m_ForwardAE, m_ForwardBE;
    logic        m_MemTimeout;
    logic [15:0] m_StallCount, m_FlushCount;

    logic        s_StallF, s_StallD, s_StallE, s_StallM, s_FlushD, s_FlushE, s_FlushW;
    logic [1:0]  s_ForwardAE, s_ForwardBE;
    logic        s_MemTimeout;
    logic [1:0]  s_StallCount, s_FlushCount;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pl_hazard_ctrl u_dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .ResultSrcE0(ResultSrcE0), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(m_StallF), .StallD(m_StallD), .StallE(m_StallE), .StallM(m_StallM),
        .FlushD(m_FlushD), .FlushE(m_FlushE), .FlushW(m_FlushW),
        .ForwardAE(m_ForwardAE), .ForwardBE(m_ForwardBE),
        .MemTimeout(m_MemTimeout), .StallCount(m_StallCount), .FlushCount(m_FlushCount)
    );

    pl_hazard_ctrl #(.TIMEOUT_CYC(4), .CNT_W(2)) u_small (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .ResultSrcE0(ResultSrcE0), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(s_StallF), .StallD(s_StallD), .StallE(s_StallE), .StallM(s_StallM),
        .FlushD(s_FlushD), .FlushE(s_FlushE), .FlushW(s_FlushW),
        .ForwardAE(s_ForwardAE), .ForwardBE(s_ForwardBE),
        .MemTimeout(s_MemTimeout), .StallCount(s_StallCount), .FlushCount(s_FlushCount)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE0 = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        RegWriteM = 1; RdM = 5; Rs1E = 5;
        step(); step();
        settle();
        check("rst_flushD", m_FlushD, 1);
        check("rst_flushE", m_FlushE, 1);
        check("rst_flushW", m_FlushW, 1);
        check("rst_stallF", m_StallF, 0);
        check("rst_fwdA", m_ForwardAE, 2'b00);
        check("rst_stallcnt", m_StallCount, 0);
        check("rst_flushcnt", m_FlushCount, 0);
        check("rst_timeout", m_MemTimeout, 0);

        // Forwarding
        reset = 1'b0;
        RegWriteW = 1; RdW = 5;
        settle();
        check("fwd_M_prio", m_ForwardAE, 2'b10);
        RdM = 3;
        settle();
        check("fwd_W", m_ForwardAE, 2'b01);
        Rs2E = 3;
        settle();
        check("fwd_B_M", m_ForwardBE, 2'b10);
        Rs1E = 0; RdM = 0; RdW = 0;
        settle();
        check("fwd_x0", m_ForwardAE, 2'b00);
        check("run_flushW", m_FlushW, 0);
        clear_inputs();

        // Load-use
        ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
        settle();
        check("lw_stallF", m_StallF, 1);
        check("lw_stallD", m_StallD, 1);
        check("lw_flushE", m_FlushE, 1);
        check("lw_flushD", m_FlushD, 0);
        check("lw_stallE", m_StallE, 0);
        step();
        ResultSrcE0 = 0;
        settle();
        check("lw_cnt", m_StallCount, 1);
        check("lw_end_stallF", m_StallF, 0);
        ResultSrcE0 = 1; RdE = 0; Rs2D = 0;
        settle();
        check("lw_x0_stallF", m_StallF, 0);
        check("lw_x0_flushE", m_FlushE, 0);
        step();
        clear_inputs();
        settle();
        check("lw_x0_cnt", m_StallCount, 1);

        // Branch
        PCSrcE = 1;
        settle();
        check("br_flushD", m_FlushD, 1);
        check("br_flushE", m_FlushE, 1);
        check("br_stallF", m_StallF, 0);
        step();
        PCSrcE = 0;
        settle();
        check("br_cnt", m_FlushCount, 1);
        check("br_end_flushD", m_FlushD, 0);

        // Memory wait: 3 frozen cycles, branch inside the wait ignored
        MemReqM = 1; MemReadyM = 0;
        for (int i = 0; i < 3; i++) begin
            PCSrcE = (i == 1);
            settle();
            check("mw_stallF", m_StallF, 1);
            check("mw_stallM", m_StallM, 1);
            check("mw_stallE", m_StallE, 1);
            check("mw_flushW", m_FlushW, 1);
            check("mw_flushD", m_FlushD, 0);
            check("mw_flushE", m_FlushE, 0);
            step();
        end
        PCSrcE = 0; MemReadyM = 1;
        settle();
        check("mw_exit_stallF", m_StallF, 0);
        check("mw_exit_flushW", m_FlushW, 0);
        step();
        MemReqM = 0; MemReadyM = 0;
        settle();
        check("mw_run_stallF", m_StallF, 0);
        check("mw_stallcnt", m_StallCount, 4);
        check("mw_flushcnt", m_FlushCount, 1);
        check("sat_stallcnt", s_StallCount, 3);
        check("mw_small_to", s_MemTimeout, 0);

        // Timeout on the small instance
        MemReqM = 1; MemReadyM = 0;
        repeat (4) step();
        settle();
        check("to_before", s_MemTimeout, 0);
        step();
        check("to_set", s_MemTimeout, 1);
        check("to_main_clear", m_MemTimeout, 0);
        MemReqM = 0; MemReadyM = 1;
        settle();
        check("to_freeze", s_StallF, 1);
        check("to_flushW", s_FlushW, 1);
        check("to_main_run", m_StallF, 0);
        step();
        check("to_sticky", s_MemTimeout, 1);
        check("to_freeze2", s_StallM, 1);
        check("sat_hold", s_StallCount, 3);

        // Reset in the middle of a wait
        MemReqM = 1; MemReadyM = 0;
        step(); step();
        reset = 1'b1;
        settle();
        check("rmw_stallF", m_StallF, 0);
        check("rmw_flushD", m_FlushD, 1);
        step();
        reset = 1'b0; MemReqM = 0;
        settle();
        check("rmw_to_clr", s_MemTimeout, 0);
        check("rmw_unfreeze", s_StallF, 0);
        check("rmw_stallcnt", m_StallCount, 0);
        check("rmw_flushcnt", m_FlushCount, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
